// File: rtl/riscv_mem_stage.sv
// MEM stage: EX results to data bus (req/gnt/rvalid) and registered WB fields.
// Formats store byte lanes, extends load data, flags misaligned/illegal ops.
module riscv_mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
   input  logic                  ex_mem_re_i,
   input  logic                  ex_mem_we_i,
   input  logic [2:0]            ex_funct3_i,
   input  logic [DATA_WIDTH-1:0] ex_mem_wdata_i,
   input  logic                  ex_reg_we_i,
   input  logic                  ex_wdata_mux_i,
   input  logic [ADDR_WIDTH-1:0] ex_dest_reg_i,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   output logic [31:0]           data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [31:0]           data_wdata_o,
   input  logic                  data_rvalid_i,
   input  logic [31:0]           data_rdata_i,
   output logic                  wb_valid_o,
   output logic                  wb_reg_we_o,
   output logic                  wb_wdata_mux_o,
   output logic [ADDR_WIDTH-1:0] wb_dest_reg_o,
   output logic [DATA_WIDTH-1:0] wb_alu_result_o,
   output logic [DATA_WIDTH-1:0] wb_mem_data_o,
   output logic                  lsu_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID} state_t;

   state_t                state;
   logic                  lat_st;
   logic [2:0]            lat_f3;
   logic [1:0]            lat_off;
   logic                  lat_reg_we;
   logic                  lat_mux;
   logic [ADDR_WIDTH-1:0] lat_dest;
   logic [DATA_WIDTH-1:0] lat_alu;

   logic [1:0]            off;
   logic                  is_mem;
   logic                  bad_f3;
   logic                  mis;
   logic                  err;
   logic [3:0]            be;
   logic [31:0]           wdat;
   logic [31:0]           sh;
   logic [DATA_WIDTH-1:0] ld_data;

   assign ex_ready_o = (state == IDLE);
   assign off        = ex_alu_result_i[1:0];
   assign is_mem     = ex_mem_re_i | ex_mem_we_i;

   // re and we both set is treated as a store
   always_comb begin
      bad_f3 = 1'b0;
      if (ex_mem_we_i)
         bad_f3 = (ex_funct3_i >= 3'b011);
      else
         bad_f3 = (ex_funct3_i == 3'b011) ||
                  (ex_funct3_i == 3'b110) ||
                  (ex_funct3_i == 3'b111);
      mis = ((ex_funct3_i[1:0] == 2'b01) && off[0]) ||
            ((ex_funct3_i[1:0] == 2'b10) && (off != 2'b00));
      err = bad_f3 | mis;
   end

   always_comb begin
      be   = 4'b1111;
      wdat = ex_mem_wdata_i[31:0];
      if (ex_mem_we_i) begin
         unique case (ex_funct3_i)
            3'b000: begin
               be   = 4'b0001 << off;
               wdat = {4{ex_mem_wdata_i[7:0]}};
            end
            3'b001: begin
               be   = off[1] ? 4'b1100 : 4'b0011;
               wdat = {2{ex_mem_wdata_i[15:0]}};
            end
            default: begin
               be   = 4'b1111;
               wdat = ex_mem_wdata_i[31:0];
            end
         endcase
      end
   end

   always_comb begin
      sh      = data_rdata_i >> {lat_off, 3'b000};
      ld_data = data_rdata_i;
      unique case (lat_f3)
         3'b000:  ld_data = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
         3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
         3'b001:  ld_data = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
         3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
         default: ld_data = data_rdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         data_req_o      <= 1'b0;
         data_we_o       <= 1'b0;
         data_be_o       <= 4'b0000;
         data_addr_o     <= '0;
         data_wdata_o    <= '0;
         wb_valid_o      <= 1'b0;
         wb_reg_we_o     <= 1'b0;
         wb_wdata_mux_o  <= 1'b0;
         wb_dest_reg_o   <= '0;
         wb_alu_result_o <= '0;
         wb_mem_data_o   <= '0;
         lsu_err_o       <= 1'b0;
         lat_st          <= 1'b0;
         lat_f3          <= '0;
         lat_off         <= '0;
         lat_reg_we      <= 1'b0;
         lat_mux         <= 1'b0;
         lat_dest        <= '0;
         lat_alu         <= '0;
      end else begin
         wb_valid_o <= 1'b0;
         lsu_err_o  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ex_valid_i) begin
                  if (is_mem && !err) begin
                     lat_st       <= ex_mem_we_i;
                     lat_f3       <= ex_funct3_i;
                     lat_off      <= off;
                     lat_reg_we   <= ex_reg_we_i;
                     lat_mux      <= ex_wdata_mux_i;
                     lat_dest     <= ex_dest_reg_i;
                     lat_alu      <= ex_alu_result_i;
                     data_req_o   <= 1'b1;
                     data_we_o    <= ex_mem_we_i;
                     data_be_o    <= be;
                     data_wdata_o <= wdat;
                     data_addr_o  <= {ex_alu_result_i[31:2], 2'b00};
                     state        <= REQ;
                  end else begin
                     wb_valid_o      <= 1'b1;
                     wb_reg_we_o     <= ex_reg_we_i & ~is_mem;
                     wb_wdata_mux_o  <= ex_wdata_mux_i;
                     wb_dest_reg_o   <= ex_dest_reg_i;
                     wb_alu_result_o <= ex_alu_result_i;
                     wb_mem_data_o   <= '0;
                     lsu_err_o       <= is_mem;
                  end
               end
            end
            REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state      <= WAIT_RVALID;
               end
            end
            WAIT_RVALID: begin
               if (data_rvalid_i) begin
                  wb_valid_o      <= 1'b1;
                  wb_reg_we_o     <= lat_reg_we;
                  wb_wdata_mux_o  <= lat_mux;
                  wb_dest_reg_o   <= lat_dest;
                  wb_alu_result_o <= lat_alu;
                  wb_mem_data_o   <= lat_st ? '0 : ld_data;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed bench for riscv_mem_stage: non-mem stream, loads, stores,
// misaligned/illegal accesses and reset in the middle of an access.
module tb_riscv_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu;
   logic        ex_re;
   logic        ex_we;
   logic [2:0]  ex_f3;
   logic [31:0] ex_wdata;
   logic        ex_reg_we;
   logic        ex_mux;
   logic [4:0]  ex_dest;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        wb_valid;
   logic        wb_reg_we;
   logic        wb_mux;
   logic [4:0]  wb_dest;
   logic [31:0] wb_alu;
   logic [31:0] wb_mem;
   logic        lsu_err;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   riscv_mem_stage dut (
      .clk             (clk),
      .rst             (rst),
      .ex_valid_i      (ex_valid),
      .ex_ready_o      (ex_ready),
      .ex_alu_result_i (ex_alu),
      .ex_mem_re_i     (ex_re),
      .ex_mem_we_i     (ex_we),
      .ex_funct3_i     (ex_f3),
      .ex_mem_wdata_i  (ex_wdata),
      .ex_reg_we_i     (ex_reg_we),
      .ex_wdata_mux_i  (ex_mux),
      .ex_dest_reg_i   (ex_dest),
      .data_req_o      (req),
      .data_gnt_i      (gnt),
      .data_addr_o     (addr),
      .data_we_o       (we),
      .data_be_o       (be),
      .data_wdata_o    (wdata),
      .data_rvalid_i   (rvalid),
      .data_rdata_i    (rdata),
      .wb_valid_o      (wb_valid),
      .wb_reg_we_o     (wb_reg_we),
      .wb_wdata_mux_o  (wb_mux),
      .wb_dest_reg_o   (wb_dest),
      .wb_alu_result_o (wb_alu),
      .wb_mem_data_o   (wb_mem),
      .lsu_err_o       (lsu_err)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_op(input string tg,
                         input logic re_, we_,
                         input logic [2:0] f3,
                         input logic [31:0] a, wd, rd,
                         input int gw,
                         input logic [3:0] ebe,
                         input logic [31:0] ewd, emd);
      ex_valid  = 1'b1;
      ex_re     = re_;
      ex_we     = we_;
      ex_f3     = f3;
      ex_alu    = a;
      ex_wdata  = wd;
      ex_reg_we = re_ & ~we_;
      ex_mux    = re_ & ~we_;
      ex_dest   = 5'd7;
      chk({tg, "_rdy_acc"}, 32'(ex_ready), 32'd1);
      tick();
      ex_valid = 1'b0;
      ex_re    = 1'b0;
      ex_we    = 1'b0;
      chk({tg, "_req"}, 32'(req), 32'd1);
      chk({tg, "_rdy_busy"}, 32'(ex_ready), 32'd0);
      chk({tg, "_addr"}, addr, {a[31:2], 2'b00});
      chk({tg, "_be"}, 32'(be), 32'(ebe));
      chk({tg, "_we"}, 32'(we), 32'(we_));
      if (we_) chk({tg, "_wdata"}, wdata, ewd);
      for (int i = 0; i < gw; i++) begin
         tick();
         chk({tg, "_req_hold"}, 32'(req), 32'd1);
         chk({tg, "_addr_hold"}, addr, {a[31:2], 2'b00});
      end
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk({tg, "_req_drop"}, 32'(req), 32'd0);
      chk({tg, "_rdy_wait"}, 32'(ex_ready), 32'd0);
      chk({tg, "_wbv_wait"}, 32'(wb_valid), 32'd0);
      rvalid = 1'b1;
      rdata  = rd;
      tick();
      rvalid = 1'b0;
      rdata  = 32'h0;
      chk({tg, "_wbv"}, 32'(wb_valid), 32'd1);
      chk({tg, "_memdata"}, wb_mem, emd);
      chk({tg, "_regwe"}, 32'(wb_reg_we), 32'(re_ & ~we_));
      chk({tg, "_dest"}, 32'(wb_dest), 32'd7);
      chk({tg, "_alu"}, wb_alu, a);
      chk({tg, "_rdy_done"}, 32'(ex_ready), 32'd1);
      tick();
      chk({tg, "_wbv_pulse"}, 32'(wb_valid), 32'd0);
   endtask

   task automatic err_op(input string tg,
                         input logic re_, we_,
                         input logic [2:0] f3,
                         input logic [31:0] a);
      ex_valid  = 1'b1;
      ex_re     = re_;
      ex_we     = we_;
      ex_f3     = f3;
      ex_alu    = a;
      ex_reg_we = 1'b1;
      ex_dest   = 5'd9;
      tick();
      ex_valid = 1'b0;
      ex_re    = 1'b0;
      ex_we    = 1'b0;
      chk({tg, "_wbv"}, 32'(wb_valid), 32'd1);
      chk({tg, "_err"}, 32'(lsu_err), 32'd1);
      chk({tg, "_regwe"}, 32'(wb_reg_we), 32'd0);
      chk({tg, "_req"}, 32'(req), 32'd0);
      chk({tg, "_rdy"}, 32'(ex_ready), 32'd1);
      tick();
      chk({tg, "_err_pulse"}, 32'(lsu_err), 32'd0);
      chk({tg, "_wbv_pulse"}, 32'(wb_valid), 32'd0);
      chk({tg, "_req_after"}, 32'(req), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      ex_valid  = 1'b0;
      ex_alu    = '0;
      ex_re     = 1'b0;
      ex_we     = 1'b0;
      ex_f3     = '0;
      ex_wdata  = '0;
      ex_reg_we = 1'b0;
      ex_mux    = 1'b0;
      ex_dest   = '0;
      gnt       = 1'b0;
      rvalid    = 1'b0;
      rdata     = '0;
      tick();
      tick();
      chk("rst_ready", 32'(ex_ready), 32'd1);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_be", 32'(be), 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_wbv", 32'(wb_valid), 32'd0);
      chk("rst_memdata", wb_mem, 32'd0);
      chk("rst_err", 32'(lsu_err), 32'd0);
      rst = 1'b0;
      tick();

      // back-to-back non-memory ops
      ex_valid  = 1'b1;
      ex_reg_we = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         ex_alu  = 32'(i * 16);
         ex_dest = 5'(i);
         chk("nm_ready", 32'(ex_ready), 32'd1);
         tick();
         chk("nm_wbv", 32'(wb_valid), 32'd1);
         chk("nm_alu", wb_alu, 32'(i * 16));
         chk("nm_dest", 32'(wb_dest), 32'(i));
         chk("nm_regwe", 32'(wb_reg_we), 32'd1);
         chk("nm_memdata", wb_mem, 32'd0);
         chk("nm_req", 32'(req), 32'd0);
      end
      ex_valid = 1'b0;
      tick();
      chk("nm_wbv_end", 32'(wb_valid), 32'd0);
      chk("nm_hold_alu", wb_alu, 32'h30);

      mem_op("lb", 1, 0, 3'b000, 32'h1003, 0, 32'h80FF_0000, 2,
             4'b1111, 0, 32'hFFFF_FF80);
      mem_op("lhu", 1, 0, 3'b101, 32'h2002, 0, 32'hBEEF_1234, 0,
             4'b1111, 0, 32'h0000_BEEF);
      mem_op("lw", 1, 0, 3'b010, 32'h2000, 0, 32'hBEEF_1234, 1,
             4'b1111, 0, 32'hBEEF_1234);
      mem_op("lh", 1, 0, 3'b001, 32'h2000, 0, 32'h1234_8001, 0,
             4'b1111, 0, 32'hFFFF_8001);
      mem_op("sb", 0, 1, 3'b000, 32'h3001, 32'h0000_00A5, 32'hDEAD_BEEF, 0,
             4'b0010, 32'hA5A5_A5A5, 0);
      mem_op("sh", 0, 1, 3'b001, 32'h3002, 32'h0000_1234, 32'hDEAD_BEEF, 1,
             4'b1100, 32'h1234_1234, 0);

      err_op("lw_mis", 1, 0, 3'b010, 32'h4002);
      err_op("sh_mis", 0, 1, 3'b001, 32'h4001);
      err_op("ld_ill", 1, 0, 3'b110, 32'h7000);
      err_op("sw_ill", 0, 1, 3'b011, 32'h7000);

      // reset while waiting for rvalid, then a late rvalid
      ex_valid = 1'b1;
      ex_re    = 1'b1;
      ex_f3    = 3'b010;
      ex_alu   = 32'h5000;
      tick();
      ex_valid = 1'b0;
      ex_re    = 1'b0;
      gnt      = 1'b1;
      tick();
      gnt = 1'b0;
      chk("ra_in_wait", 32'(ex_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ra_req", 32'(req), 32'd0);
      chk("ra_ready", 32'(ex_ready), 32'd1);
      chk("ra_wbv", 32'(wb_valid), 32'd0);
      rvalid = 1'b1;
      rdata  = 32'h1111_2222;
      tick();
      rvalid = 1'b0;
      chk("ra_late_wbv", 32'(wb_valid), 32'd0);
      chk("ra_late_rdy", 32'(ex_ready), 32'd1);
      mem_op("post_rst", 1, 0, 3'b100, 32'h6005, 0, 32'hCAFE_F00D, 0,
             4'b1111, 0, 32'h0000_00F0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
